// File: rtl/mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_sequencer_if
// Purpose  : Request/response bundle between the pipeline and mult_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             Flush;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Signed, In1, In2, Flush,
    input  Busy, Stall, Done, HI, LO
  );

  modport slave (
    input  Start, Signed, In1, In2, Flush,
    output Busy, Stall, Done, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mult_sequencer
// Purpose  : Iterative shift-add multiplier (mult/multu) with HI/LO results.
// Revision : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mult_sequencer_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               w_accepting;
  logic               w_accept;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accepting = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_accept    = bus.Start && w_accepting;

  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude.
  assign w_abs1 = (bus.Signed && bus.In1[WIDTH-1]) ? -bus.In1 : bus.In1;
  assign w_abs2 = (bus.Signed && bus.In2[WIDTH-1]) ? -bus.In2 : bus.In2;

  assign w_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (mplier_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
  assign w_prod = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (bus.Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d    = {w_sum, acc_q[WIDTH-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = S_FIX;
        end
        S_FIX: begin
          hi_d    = w_prod[2*WIDTH-1:WIDTH];
          lo_d    = w_prod[WIDTH-1:0];
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: ;
      endcase

      if (w_accept) begin
        mcand_d  = w_abs1;
        mplier_d = w_abs2;
        neg_d    = bus.Signed && (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.Busy  = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.Done  = (state_q == S_DONE);
  assign bus.Stall = bus.Busy || w_accept;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_sequencer
// Purpose  : Self-checking bench for mult_sequencer (vectors, random, corners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mult_sequencer_if #(.WIDTH(32)) bus ();

  mult_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic sg, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sg) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Entered and left at #1 after a rising edge; lat counts edges from acceptance to Done.
  task automatic do_mult(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_err);
    bus.Start  = 1'b1;
    bus.Signed = sg;
    bus.In1    = a;
    bus.In2    = b;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    lat = 0;
    busy_err = 0;
    while (!bus.Done && lat < 100) begin
      if (!bus.Busy) busy_err++;
      @(posedge clk);
      #1 lat++;
    end
    if (bus.Busy) busy_err++;
  endtask

  initial begin
    int lat, berr, cnt;
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic rs;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.Start = 1'b0; bus.Signed = 1'b0; bus.In1 = '0; bus.In2 = '0; bus.Flush = 1'b0;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[7] = '{1'b0, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E};
    vecs[8] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    check("reset_busy_done_stall", {61'd0, bus.Busy, bus.Done, bus.Stall}, 64'd0);
    bus.Start = 1'b1;
    #1 check("stall_on_start_idle", {63'd0, bus.Stall}, 64'd1);
    bus.Flush = 1'b1;
    @(posedge clk);
    #1 check("flush_beats_start", {63'd0, bus.Busy}, 64'd0);
    bus.Flush = 1'b0;
    bus.Start = 1'b0;

    // Fixed vectors: latency, Busy window, result, one-cycle Done.
    for (int i = 0; i < 9; i++) begin
      do_mult(vecs[i].sg, vecs[i].a, vecs[i].b, lat, berr);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_busy", i), 64'(berr), 64'd0);
      check($sformatf("vec%0d_result", i), {bus.HI, bus.LO}, {vecs[i].hi, vecs[i].lo});
      @(posedge clk);
      #1 check($sformatf("vec%0d_done_pulse", i), {63'd0, bus.Done}, 64'd0);
    end

    // Back-to-back: Start issued in the DONE cycle.
    do_mult(1'b1, 32'h00001234, 32'hFFFF0000, lat, berr);
    check("b2b_first", {bus.HI, bus.LO}, ref_product(1'b1, 32'h00001234, 32'hFFFF0000));
    do_mult(1'b0, 32'd5, 32'd6, lat, berr);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_result", {bus.HI, bus.LO}, 64'd30);

    // Flush at RUN iteration 10 after a result of HI=1, LO=2.
    do_mult(1'b0, 32'd2, 32'h80000001, lat, berr);
    check("pre_flush_result", {bus.HI, bus.LO}, 64'h00000001_00000002);
    bus.Start = 1'b1; bus.Signed = 1'b1; bus.In1 = 32'h0BADF00D; bus.In2 = 32'h12345678;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.Flush = 1'b1;
    check("flush_busy_before", {63'd0, bus.Busy}, 64'd1);
    @(posedge clk);
    #1 bus.Flush = 1'b0;
    check("flush_idle", {63'd0, bus.Busy}, 64'd0);
    check("flush_hilo", {bus.HI, bus.LO}, 64'h00000001_00000002);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.Done) cnt++;
    end
    check("flush_no_done", 64'(cnt), 64'd0);

    // Start held during RUN with changing operands is ignored.
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.In1 = 32'h12345678; bus.In2 = 32'h9ABCDEF0;
    @(posedge clk);
    lat = 0;
    berr = 0;
    repeat (20) begin
      #1 bus.In1 = $urandom; bus.In2 = $urandom; bus.Signed = 1'($urandom_range(0, 1));
      if (!bus.Stall) berr++;
      @(posedge clk);
      lat++;
    end
    #1 bus.Start = 1'b0;
    while (!bus.Done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("held_start_stall", 64'(berr), 64'd0);
    check("held_start_latency", 64'(lat), 64'd33);
    check("held_start_result", {bus.HI, bus.LO}, ref_product(1'b0, 32'h12345678, 32'h9ABCDEF0));

    // Randomized operands, biased toward corner values.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'h0;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      exp = ref_product(rs, ra, rb);
      do_mult(rs, ra, rb, lat, berr);
      check($sformatf("rand%0d s=%0d %h*%h", i, rs, ra, rb), {bus.HI, bus.LO}, exp);
      if (lat != 33) check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
    end

    // Reset in the middle of RUN.
    bus.Start = 1'b1; bus.Signed = 1'b1; bus.In1 = 32'hDEADBEEF; bus.In2 = 32'h00C0FFEE;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrun_reset_hilo", {bus.HI, bus.LO}, 64'd0);
    check("midrun_reset_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.Done || bus.Busy) cnt++;
    end
    check("midrun_reset_quiet", 64'(cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; HI/LO each WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request a multiply; sampled on the rising clk edge.
REQ-005 SHALL have port Signed  input  1  1 = mult (two's complement), 0 = multu; sampled with Start.
REQ-006 SHALL have ports In1, In2  input  WIDTH  multiplicand and multiplier; sampled with Start.
REQ-007 SHALL have port Flush  input  1  abort any in-progress multiply.
REQ-008 SHALL have port Busy  output  1  high while the state is RUN or FIX.
REQ-009 SHALL have port Stall  output  1  combinational: Busy OR (Start AND an accepting state), so the pipeline holds the issuing instruction.
REQ-010 SHALL have port Done  output  1  one-cycle pulse when the state is DONE.
REQ-011 SHALL have ports HI, LO  output  WIDTH  upper/lower halves of the last completed product.

Function
REQ-012 SHALL implement four registered states: IDLE, RUN, FIX, DONE.
REQ-013 SHALL accept Start only in IDLE or DONE; Start in RUN or FIX SHALL be ignored, with no queuing.
REQ-014 On acceptance SHALL latch |In1| and |In2| when Signed=1 (raw values when Signed=0), latch neg = In1[MSB] XOR In2[MSB] when Signed=1 (0 otherwise), clear the 2*WIDTH accumulator and iteration counter, and go to RUN.
REQ-015 Magnitude of the most negative value (0x80000000) SHALL be treated as unsigned 2^31 without overflow.
REQ-016 Each RUN cycle SHALL do shift-add: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half with a WIDTH+1-bit carry; then shift the accumulator/multiplier right by 1.
REQ-017 RUN SHALL last exactly WIDTH cycles, counted 0..WIDTH-1, then go to FIX.
REQ-018 FIX SHALL two's-complement-negate the 2*WIDTH product when neg=1, then go to DONE and write HI/LO on that same edge.
REQ-019 Latency SHALL be fixed: with Start accepted at edge E0, HI/LO update at edge E(WIDTH+1) and Done is high for the following cycle only (E33 for WIDTH=32).
REQ-020 DONE SHALL go to IDLE next edge unless a new Start is accepted, in which case it goes to RUN (back-to-back operation).
REQ-021 HI/LO SHALL change only on the DONE-entry edge and on reset; they SHALL hold their value otherwise, including during RUN.
REQ-022 Flush in any state SHALL force IDLE on the next edge, leave HI/LO unchanged, and produce no Done; Flush SHALL take priority over a simultaneous Start.
REQ-023 The result SHALL equal the exact 64-bit product (signed or unsigned per Signed) for all operand pairs, including 0 and all-ones.

Reset
REQ-024 When reset is high at a rising edge: state=IDLE, HI=0, LO=0, counter=0, accumulator=0, Busy=0, Done=0.
REQ-025 Reset SHALL take priority over Flush and Start and SHALL abort an in-progress multiply with no Done.
REQ-026 Stall SHALL be 0 after reset while Start=0.

Verification
REQ-027 SHALL cover: multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, Done exactly at E33, Busy high E0..E32.
REQ-028 SHALL cover: mult -3 (0xFFFFFFFD) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; the same operands as multu -> HI=0x00000006, LO=0xFFFFFFEB.
REQ-029 SHALL cover: mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000; mult 0x80000000 x 1 -> HI=0xFFFFFFFF, LO=0x80000000.
REQ-030 SHALL cover: Flush at RUN iteration 10 after a prior result HI=0x1, LO=0x2 -> IDLE next edge, HI/LO stay 0x1/0x2, no Done pulse.
REQ-031 SHALL cover: Start held high during RUN is ignored and the result matches the first operands; Start in the DONE cycle with 5 x 6 -> second Done 34 edges later with LO=30, HI=0.
REQ-032 SHALL cover: reset asserted mid-RUN -> next edge HI=LO=0, Busy=0, Done=0, and no Done afterwards.
